// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ctrl_pkg                                               |
// | Description : Shared state encoding and default sizing for the       |
// |               engine-facing sequence controllers.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ctrl_pkg;

  // 3-bit state encoding; IDLE must stay at zero so a cleared register is idle
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_SHIFT  = 3'd5;

  localparam int DEF_WORDS   = 4;
  localparam int DEF_TIMEOUT = 256;
  localparam int DEF_TMR_W   = 9;

endpackage
`default_nettype wire

// File: rtl/timeout_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : timeout_timer                                          |
// | Description : Cycle counter with clear/enable that flags the last    |
// |               allowed cycle (count == TIMEOUT-1). TIMEOUT=0 disables.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module timeout_timer #(
  parameter int TIMEOUT = 256,
  parameter int TMR_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // Count enabled cycles; clear has priority so a relaunch always starts at zero
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      // Asserted during the TIMEOUT-th enabled cycle
      assign expired = enable && (count == TMR_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multiword_seq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : multiword_seq_controller                               |
// | Description : Loads a UI word, then for each of WORDS words launches |
// |               the engine, waits for completion (with timeout),       |
// |               writes the result via req/ack and shifts the datapath. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module multiword_seq_controller
  import ctrl_pkg::*;
#(
  parameter int WORDS   = DEF_WORDS,
  parameter int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TMR_W   = DEF_TMR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             eng_done,
  input  logic             wr_ack,
  input  logic             abort,
  output logic             ld,
  output logic             ui_reg_ld,
  output logic             eng_start,
  output logic             wr_req,
  output logic             sh_en,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [2:0] state;
  logic       tmr_expired;

  timeout_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_LAUNCH),
    .enable  (state == S_WAIT),
    .expired (tmr_expired)
  );

  // Sequencer: abort overrides every transition; done is a one-cycle pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      word_idx    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_ARM;
              word_idx    <= '0;
              timeout_err <= 1'b0;
            end
          end
          // Job starts on release of the start level
          S_ARM: begin
            if (!start) state <= S_LAUNCH;
          end
          S_LAUNCH: begin
            state <= S_WAIT;
          end
          // Completion beats a timeout landing in the same cycle
          S_WAIT: begin
            if (eng_done) begin
              state <= S_WRITE;
            end else if (tmr_expired) begin
              state       <= S_IDLE;
              timeout_err <= 1'b1;
            end
          end
          S_WRITE: begin
            if (wr_ack) begin
              if (word_idx == LAST_IDX) begin
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                state <= S_SHIFT;
              end
            end
          end
          // Only reached when word_idx < LAST_IDX, so no wrap is possible
          S_SHIFT: begin
            word_idx <= word_idx + 1'b1;
            state    <= S_LAUNCH;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Moore output decode
  always_comb begin
    ld        = (state == S_ARM);
    ui_reg_ld = (state == S_ARM);
    eng_start = (state == S_LAUNCH);
    wr_req    = (state == S_WRITE);
    sh_en     = (state == S_SHIFT);
    busy      = (state != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_multiword_seq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_multiword_seq_controller                            |
// | Description : Bench for multiword_seq_controller. Expected per-cycle |
// |               outputs come from a job-level timeline model (phase    |
// |               lengths computed from latencies and ack delays).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_multiword_seq_controller;

  logic clk = 1'b0;
  logic rst0, rst1, start, eng_done, wr_ack, abort;

  logic       ld0, ui0, es0, wr0, sh0, busy0, done0, terr0;
  logic [1:0] idx0;
  logic       ld1, ui1, es1, wr1, sh1, busy1, done1, terr1;
  logic [0:0] idx1;

  always #5 clk = ~clk;

  multiword_seq_controller #(.WORDS(4), .TIMEOUT(8), .TMR_W(9)) dut (
    .clk(clk), .rst(rst0), .start(start), .eng_done(eng_done), .wr_ack(wr_ack),
    .abort(abort), .ld(ld0), .ui_reg_ld(ui0), .eng_start(es0), .wr_req(wr0),
    .sh_en(sh0), .word_idx(idx0), .busy(busy0), .done(done0), .timeout_err(terr0)
  );

  multiword_seq_controller #(.WORDS(1), .TIMEOUT(4), .TMR_W(3)) dut1 (
    .clk(clk), .rst(rst1), .start(start), .eng_done(eng_done), .wr_ack(wr_ack),
    .abort(abort), .ld(ld1), .ui_reg_ld(ui1), .eng_start(es1), .wr_req(wr1),
    .sh_en(sh1), .word_idx(idx1), .busy(busy1), .done(done1), .timeout_err(terr1)
  );

  // Output vector: {ld, ui_reg_ld, eng_start, wr_req, sh_en, busy, done, timeout_err, idx[1:0]}
  logic [9:0] vec0, vec1;
  assign vec0 = {ld0, ui0, es0, wr0, sh0, busy0, done0, terr0, idx0};
  assign vec1 = {ld1, ui1, es1, wr1, sh1, busy1, done1, terr1, 1'b0, idx1};

  typedef struct packed {
    logic       start;
    logic       eng_done;
    logic       wr_ack;
    logic       abort;
    logic [9:0] exp;
  } step_t;

  step_t q[$];
  int    checks = 0;
  int    fails  = 0;
  int    stepn  = 0;
  logic  sel    = 1'b0;
  logic  noise  = 1'b0;
  int    m_words, m_timeout, m_idx;
  logic  m_done, m_terr;

  // Pulse counters
  logic mon = 1'b0;
  int   cnt_es, cnt_wr, cnt_sh, cnt_done, cnt_sh1;
  logic wr_prev;
  always @(negedge clk) begin
    if (mon) begin
      cnt_es   += int'(es0);
      cnt_sh   += int'(sh0);
      cnt_done += int'(done0);
      if (wr0 && !wr_prev) cnt_wr += 1;
    end
    wr_prev = wr0;
    if (sel) cnt_sh1 += int'(sh1);
  end

  function automatic logic [9:0] ev(logic l, logic es, logic wr, logic sh, logic b,
                                    logic dn, logic te, int idx);
    logic [1:0] i2;
    i2 = idx[1:0];
    return {l, l, es, wr, sh, b, dn, te, i2};
  endfunction

  // Random level on inputs the controller must ignore in the current phase
  function automatic logic nz();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void push(logic st, logic ed, logic wa, logic ab, logic [9:0] e);
    step_t s;
    s.start = st; s.eng_done = ed; s.wr_ack = wa; s.abort = ab; s.exp = e;
    q.push_back(s);
  endfunction

  function automatic void add_idle(int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, nz(), nz(), nz(), ev(0, 0, 0, 0, 0, m_done, m_terr, m_idx));
      m_done = 1'b0;
    end
  endfunction

  // Start held for 1+h cycles (one sampled in IDLE), then released
  function automatic void add_arm(int h);
    push(1'b1, nz(), nz(), 1'b0, ev(0, 0, 0, 0, 0, m_done, m_terr, m_idx));
    m_done = 1'b0; m_terr = 1'b0; m_idx = 0;
    for (int i = 0; i < h; i++) push(1'b1, nz(), nz(), 1'b0, ev(1, 0, 0, 0, 1, 0, 0, 0));
    push(1'b0, nz(), nz(), 1'b0, ev(1, 0, 0, 0, 1, 0, 0, 0));
  endfunction

  // One word: launch, L wait cycles, D+1 write cycles, shift unless last.
  // ab: 0 none, 1 abort during shift, 2 abort together with the ack
  function automatic void add_word(int w, int L, int D, int ab);
    logic last;
    last = (w == m_words - 1);
    push(1'b0, nz(), nz(), 1'b0, ev(0, 1, 0, 0, 1, 0, 0, w));
    for (int j = 1; j <= L; j++) push(1'b0, (j == L), nz(), 1'b0, ev(0, 0, 0, 0, 1, 0, 0, w));
    for (int j = 0; j <= D; j++)
      push(1'b0, nz(), (j == D), (ab == 2 && j == D), ev(0, 0, 1, 0, 1, 0, 0, w));
    m_idx = w;
    if (ab == 2) return;
    if (last) begin
      m_done = 1'b1;
      return;
    end
    push(1'b0, nz(), nz(), (ab == 1), ev(0, 0, 0, 1, 1, 0, 0, w));
    if (ab != 1) m_idx = w + 1;
  endfunction

  function automatic void add_timeout(int w);
    push(1'b0, nz(), nz(), 1'b0, ev(0, 1, 0, 0, 1, 0, 0, w));
    for (int j = 0; j < m_timeout; j++) push(1'b0, 1'b0, nz(), 1'b0, ev(0, 0, 0, 0, 1, 0, 0, w));
    m_idx = w; m_terr = 1'b1; m_done = 1'b0;
  endfunction

  function automatic void add_job(int L, int hold);
    add_arm(hold);
    for (int w = 0; w < m_words; w++) add_word(w, L, 0, 0);
  endfunction

  task automatic run_q();
    step_t      s;
    logic [9:0] obs;
    while (q.size() > 0) begin
      s = q.pop_front();
      start = s.start; eng_done = s.eng_done; wr_ack = s.wr_ack; abort = s.abort;
      @(negedge clk);
      obs = sel ? vec1 : vec0;
      checks++;
      assert (obs === s.exp) else begin
        fails++;
        $error("FAIL trace step %0d: observed %b required %b", stepn, obs, s.exp);
      end
      stepn++;
      @(posedge clk); #1;
    end
    start = 1'b0; eng_done = 1'b0; wr_ack = 1'b0; abort = 1'b0;
  endtask

  task automatic chk(string tag, int obs, int req);
    checks++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; start = 1'b0; eng_done = 1'b0; wr_ack = 1'b0; abort = 1'b0;
    m_words = 4; m_timeout = 8; m_idx = 0; m_done = 1'b0; m_terr = 1'b0;
    cnt_es = 0; cnt_wr = 0; cnt_sh = 0; cnt_done = 0; cnt_sh1 = 0; wr_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
    @(negedge clk);
    chk("reset0_outputs", int'(vec0), 0);
    @(posedge clk); #1;

    // Directed job: start high 3 cycles, latency 5, immediate ack
    mon = 1'b1;
    add_idle(1); add_job(5, 2); add_idle(2);
    run_q();
    mon = 1'b0;
    chk("eng_start_pulses", cnt_es, 4);
    chk("wr_req_count", cnt_wr, 4);
    chk("sh_en_pulses", cnt_sh, 3);
    chk("done_pulses", cnt_done, 1);

    // Word 1 write acknowledged late: wr_req held 7 cycles
    add_arm(0);
    for (int w = 0; w < 4; w++) add_word(w, 5, (w == 1) ? 6 : 0, 0);
    add_idle(1);
    run_q();

    // Engine never answers on word 1; next start clears the error
    add_arm(1); add_word(0, 3, 0, 0); add_timeout(1); add_idle(3);
    add_job(4, 0); add_idle(1);
    run_q();

    // Abort during the shift of word 2, then a clean job
    add_arm(1); add_word(0, 3, 0, 0); add_word(1, 2, 1, 0); add_word(2, 3, 1, 1);
    add_idle(2); add_job(2, 0); add_idle(1);
    run_q();

    // Abort coinciding with the final ack: no done
    add_arm(0);
    for (int w = 0; w < 3; w++) add_word(w, 2, 0, 0);
    add_word(3, 2, 2, 2); add_idle(2);
    run_q();

    // Randomised jobs with ignored-input noise
    noise = 1'b1;
    for (int k = 0; k < 8; k++) begin
      add_idle($urandom_range(0, 2));
      add_arm($urandom_range(0, 3));
      for (int w = 0; w < m_words; w++) begin
        int ab;
        ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
        if (ab == 1 && w == m_words - 1) ab = 0;
        if ($urandom_range(0, 11) == 0) begin
          add_timeout(w);
          break;
        end
        add_word(w, $urandom_range(1, m_timeout), $urandom_range(0, 3), ab);
        if (ab != 0) break;
      end
    end
    add_idle(2);
    run_q();
    noise = 1'b0;

    // Reset in the middle of a WAIT on word 1, with start and eng_done high
    add_arm(0); add_word(0, 2, 0, 0);
    push(1'b0, 1'b0, 1'b0, 1'b0, ev(0, 1, 0, 0, 1, 0, 0, 1));
    for (int j = 0; j < 3; j++) push(1'b0, 1'b0, 1'b0, 1'b0, ev(0, 0, 0, 0, 1, 0, 0, 1));
    run_q();
    rst0 = 1'b0; start = 1'b1; eng_done = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b1; start = 1'b0; eng_done = 1'b0;
    @(negedge clk);
    chk("reset_mid_wait", int'(vec0), 0);
    @(posedge clk); #1;
    m_idx = 0; m_done = 1'b0; m_terr = 1'b0;
    add_idle(1); add_job(3, 1); add_idle(1);
    run_q();

    // Single-word instance, TIMEOUT=4
    rst0 = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b1; sel = 1'b1;
    m_words = 1; m_timeout = 4; m_idx = 0; m_done = 1'b0; m_terr = 1'b0;
    @(negedge clk);
    chk("reset1_outputs", int'(vec1), 0);
    @(posedge clk); #1;
    add_idle(1); add_arm(1); add_word(0, 4, 0, 0); add_idle(2);
    add_arm(0); add_timeout(0); add_idle(2);
    add_arm(0); add_word(0, 2, 3, 0); add_idle(1);
    run_q();
    noise = 1'b1;
    for (int k = 0; k < 5; k++) begin
      add_arm($urandom_range(0, 2));
      add_word(0, $urandom_range(1, m_timeout), $urandom_range(0, 3), 0);
      add_idle($urandom_range(1, 2));
    end
    run_q();
    noise = 1'b0;
    chk("words1_sh_en_pulses", cnt_sh1, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiword_seq_controller.md
Name: multiword_seq_controller

Overview:
- Parametrised successor to the lab's fixed 4-word load/engine/write/shift controller.
- Loads a user word, then for each of WORDS words: launches the engine, waits for its completion, writes the result with a req/ack handshake, and shifts the datapath.
- Adds engine timeout detection, write-acknowledge handshake, abort, a word index output and a completion pulse.
- Sits between the UI register/shift datapath, the processing engine and the memory-write port.

Parameters:
- WORDS, 4, number of engine/write iterations per job (>=1).
- IDX_W, $clog2(WORDS) (min 1), width of word_idx.
- TIMEOUT, 256, max cycles spent in WAIT before error; 0 disables timeout.
- TMR_W, 9, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-low reset.
- start, input, 1, job request level from UI.
- eng_done, input, 1, engine completion strobe.
- wr_ack, input, 1, write port accepted the current wr_req.
- abort, input, 1, cancel the current job.
- ld, output, 1, datapath load enable.
- ui_reg_ld, output, 1, UI register load enable.
- eng_start, output, 1, one-cycle engine launch.
- wr_req, output, 1, write request, held until acknowledged.
- sh_en, output, 1, datapath shift enable.
- word_idx, output, IDX_W, index of the word in progress.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse on normal job completion.
- timeout_err, output, 1, sticky engine-timeout flag.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; word_idx, timer, done and timeout_err are 0; all Moore outputs 0. Reset has priority over all inputs.
- States: IDLE, ARM, LAUNCH, WAIT, WRITE, SHIFT. Moore outputs decode from state only.
- IDLE: outputs 0. start==1 -> ARM, clear word_idx and timeout_err.
- ARM: ld=ui_reg_ld=1 every cycle. Stay while start==1; start==0 -> LAUNCH (release-triggered, as in the previous generation).
- LAUNCH: eng_start=1 for exactly 1 cycle; timer cleared -> WAIT. eng_done in LAUNCH is ignored.
- WAIT: timer increments each cycle.
  - eng_done==1 -> WRITE.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1 -> IDLE with timeout_err<=1 and no done.
  - If eng_done and timeout coincide, eng_done wins.
- WRITE: wr_req=1 until wr_ack is sampled high.
  - On ack with word_idx==WORDS-1 -> IDLE and done<=1 (done is high the cycle after the ack).
  - On ack otherwise -> SHIFT.
  - wr_ack outside WRITE is ignored.
- SHIFT: sh_en=1 for 1 cycle; word_idx increments -> LAUNCH. word_idx never wraps within a job.
- abort==1 in any non-IDLE state -> IDLE next cycle. No done, timeout_err unchanged, word_idx frozen.
- Priority: reset > abort > state transitions.
- done is registered and cleared the following cycle. timeout_err holds until reset or the next IDLE->ARM.
- Timing: with engine latency L (eng_done in the L-th WAIT cycle) and zero-wait ack, a job takes ARM + WORDS*(L+2) + (WORDS-1) cycles from start release to IDLE.
- WORDS==1: SHIFT is never entered and sh_en never asserts.

Decomposition:
- Shared package `ctrl_pkg`:
  - state enum/localparams (3-bit encoding, IDLE=0);
  - default WORDS/TIMEOUT constants.
- Sub-module `timeout_timer`: clear, enable, TIMEOUT compare, expired output. Reusable by other engine-facing controllers.
- Everything else stays in one module.

Test Plan:
- Reset mid-WAIT (rst low for 1 cycle) -> next cycle: state IDLE, busy=0, all outputs 0, word_idx=0.
- WORDS=4, start high 3 cycles then low, eng_done 5 cycles after each eng_start, wr_ack immediate ->
  - 4 eng_start pulses, 4 wr_req, 3 sh_en pulses;
  - word_idx runs 0..3;
  - done pulses once, 1 cycle after the 4th ack.
- wr_ack delayed 7 cycles on word 1 -> wr_req held high 7 cycles; no sh_en or eng_start until the ack; word_idx stays 1.
- TIMEOUT=8, eng_done never arrives -> after 8 WAIT cycles: state IDLE, timeout_err=1, done=0. Next start clears timeout_err.
- abort asserted in the SHIFT of word 2 -> IDLE next cycle, no done, word_idx=2 retained; a later start runs a full clean job.
- WORDS=1, and eng_done coincident with the timeout cycle (TIMEOUT=4, eng_done on the 4th WAIT cycle) -> proceeds to WRITE, sh_en never asserted, done pulses, timeout_err=0.
